// File: rtl/sequence_feeder.sv
// sequence_feeder: holds a parallel pattern and plays it out MSB-first on X, one bit per step
module sequence_feeder #(
  parameter int WIDTH = 44,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [LEN_W-1:0] length_in,
  input  logic             start,
  input  logic             step,
  input  logic             loop,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bits_left
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d, shift_q, shift_d, eff_pat;
  logic [LEN_W-1:0] len_q, len_d, bits_left_q, bits_left_d, ld_len, eff_len;
  logic             x_q, x_d, x_valid_q, x_valid_d, ld, st;
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] n);
    return p << (LEN_W'(WIDTH) - n);
  endfunction
  // next-state: load/start are honoured only outside SHIFT; a same-cycle load feeds the start
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    x_d         = x_q;
    x_valid_d   = 1'b0;
    ld          = load && state_q != SHIFT;
    ld_len      = (length_in == '0 || length_in > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length_in;
    eff_len     = ld ? ld_len : len_q;
    eff_pat     = ld ? pattern_in : pattern_q;
    st          = start && state_q != SHIFT && eff_len != '0;
    if (ld) begin
      pattern_d = pattern_in;
      len_d     = ld_len;
      state_d   = IDLE;
    end
    if (st) begin
      shift_d     = align(eff_pat, eff_len);
      bits_left_d = eff_len;
      state_d     = SHIFT;
    end
    if (state_q == SHIFT && step) begin
      x_d         = shift_q[WIDTH-1];
      x_valid_d   = 1'b1;
      shift_d     = shift_q << 1;
      bits_left_d = bits_left_q - LEN_W'(1);
      if (bits_left_q == LEN_W'(1)) begin
        shift_d     = loop ? align(pattern_q, len_q) : shift_q << 1;
        bits_left_d = loop ? len_q : '0;
        state_d     = loop ? SHIFT : DONE;
      end
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
    end
  end
  assign X         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = state_q == SHIFT;
  assign done      = state_q == DONE;
  assign bits_left = bits_left_q;
endmodule

// File: tb/tb_sequence_feeder.sv
// tb_sequence_feeder: vector-table and directed checks for sequence_feeder
module tb_sequence_feeder;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0, start = 1'b0, step = 1'b0, loop = 1'b0;
  logic [43:0] pattern_in = '0;
  logic [5:0]  length_in = '0;
  logic        X, x_valid, busy, done;
  logic [5:0]  bits_left;
  int          vecs = 0, errs = 0;

  sequence_feeder dut (
    .clk(clk), .reset(reset), .load(load), .pattern_in(pattern_in), .length_in(length_in),
    .start(start), .step(step), .loop(loop), .X(X), .x_valid(x_valid), .busy(busy),
    .done(done), .bits_left(bits_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic [43:0] pat; logic [5:0] len; logic st, stp, lp;
    logic x, xv, bsy, dn; logic [5:0] bl;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic x, input logic xv, input logic bsy,
                         input logic dn, input logic [5:0] bl);
    chk({tag, ".X"}, 64'(X), 64'(x));
    chk({tag, ".x_valid"}, 64'(x_valid), 64'(xv));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".bits_left"}, 64'(bits_left), 64'(bl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [43:0] pat, input logic [5:0] len,
                       input logic st, input logic stp, input logic lp);
    load = ld; pattern_in = pat; length_in = len; start = st; step = stp; loop = lp;
  endtask

  task automatic mid_reset(input string tag);
    #3 reset = 1'b1;
    #1 chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    drive(0, '0, '0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [43:0] p44;
    logic [7:0]  p8;
    int          eb;
    logic        ex;
    p44 = 44'b01100010101101011011111001011011011011101010;
    p8  = 8'hB5;
    tbl[0]  = '{1, 44'h0B5, 6'd8, 1, 1, 0,  0, 0, 1, 0, 6'd8};
    tbl[1]  = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd7};
    tbl[2]  = '{0, '0, '0, 0, 1, 0,  0, 1, 1, 0, 6'd6};
    tbl[3]  = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd5};
    tbl[4]  = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd4};
    tbl[5]  = '{0, '0, '0, 0, 1, 0,  0, 1, 1, 0, 6'd3};
    tbl[6]  = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd2};
    tbl[7]  = '{0, '0, '0, 0, 1, 0,  0, 1, 1, 0, 6'd1};
    tbl[8]  = '{0, '0, '0, 0, 1, 0,  1, 1, 0, 1, 6'd0};
    tbl[9]  = '{0, '0, '0, 0, 0, 0,  1, 0, 0, 1, 6'd0};
    tbl[10] = '{1, 44'h6, 6'd3, 0, 0, 0,  1, 0, 0, 0, 6'd0};
    tbl[11] = '{0, '0, '0, 1, 1, 1,  1, 0, 1, 0, 6'd3};
    tbl[12] = '{0, '0, '0, 0, 1, 1,  1, 1, 1, 0, 6'd2};
    tbl[13] = '{0, '0, '0, 0, 1, 1,  1, 1, 1, 0, 6'd1};
    tbl[14] = '{0, '0, '0, 0, 1, 1,  0, 1, 1, 0, 6'd3};
    tbl[15] = '{0, '0, '0, 0, 1, 1,  1, 1, 1, 0, 6'd2};
    tbl[16] = '{0, '0, '0, 0, 1, 1,  1, 1, 1, 0, 6'd1};
    tbl[17] = '{0, '0, '0, 0, 1, 1,  0, 1, 1, 0, 6'd3};
    tbl[18] = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd2};
    tbl[19] = '{0, '0, '0, 0, 1, 0,  1, 1, 1, 0, 6'd1};
    tbl[20] = '{0, '0, '0, 0, 1, 0,  0, 1, 0, 1, 6'd0};
    tbl[21] = '{0, '0, '0, 0, 0, 0,  0, 0, 0, 1, 6'd0};
    tbl[22] = '{1, '0, 6'd50, 1, 0, 0,  0, 0, 1, 0, 6'd44};

    tick();
    tick();
    reset = 1'b0;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    drive(0, '0, '0, 1, 1, 0);
    tick();
    chk("start_no_len.busy", 64'(busy), 64'd0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].st, tbl[i].stp, tbl[i].lp);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].xv, tbl[i].bsy, tbl[i].dn, tbl[i].bl);
    end
    mid_reset("async_reset1");

    drive(1, p44, 6'd0, 1, 1, 0);
    tick();
    chk_all("clamp.start", 1'b0, 1'b0, 1'b1, 1'b0, 6'd44);
    drive(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 44; i++) begin
      tick();
      chk($sformatf("clamp.X%0d", i), 64'(X), 64'(p44[43-i]));
      chk($sformatf("clamp.bl%0d", i), 64'(bits_left), 64'(43 - i));
    end
    chk("clamp.done", 64'(done), 64'd1);

    drive(1, 44'h0B5, 6'd8, 1, 0, 0);
    tick();
    eb = 8;
    ex = X;
    for (int c = 0; c < 32; c++) begin
      drive(c % 4 == 2, 44'hFFF, 6'd2, c % 4 == 1, c % 4 == 3, 0);
      tick();
      if (c % 4 == 3) begin
        ex = p8[eb-1];
        eb--;
      end
      chk_all($sformatf("gated%0d", c), ex, c % 4 == 3, eb != 0, eb == 0, 6'(eb));
    end

    drive(1, 44'h0B5, 6'd8, 1, 1, 0);
    tick();
    drive(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("midrun.bits_left", 64'(bits_left), 64'd3);
    mid_reset("async_reset2");
    drive(0, '0, '0, 1, 1, 0);
    tick();
    chk("post_reset_start.busy", 64'(busy), 64'd0);
    drive(1, 44'h0B5, 6'd8, 1, 1, 0);
    tick();
    chk_all("load_start", 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
    drive(0, '0, '0, 0, 1, 0);
    tick();
    chk_all("load_start.bit0", 1'b1, 1'b1, 1'b1, 1'b0, 6'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
